digit_counter_param: RTL and testbench

//  Generalised single-digit counter for the clock display chain: one instance per digit.

---
 rtl/digit_counter_param_pkg.sv | 58 +++++
 rtl/digit_counter_param_if.sv | 23 ++
 rtl/digit_counter_param_button_edge_repeat.sv | 93 +++++++++
 rtl/digit_counter_param.sv | 130 +++++++++++++
 tb/tb_digit_counter_param.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/digit_counter_param_pkg.sv
// rtl/digit_counter_param_pkg.sv - shared types and arithmetic helpers for the digit counter
package digit_pkg;

    localparam int ARITH_W = 17;
    typedef logic [ARITH_W-1:0] arith_t;

    localparam arith_t ARITH_ONE = arith_t'(1);
    localparam arith_t ARITH_TWO = arith_t'(2);

    // Net step applied to the digit in one cycle: tick + plus - minus.
    typedef enum logic [1:0] {
        STEP_M1 = 2'd0,
        STEP_0  = 2'd1,
        STEP_P1 = 2'd2,
        STEP_P2 = 2'd3
    } step_e;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HOLD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_e;

    typedef struct packed {
        logic   wrapped_up;
        arith_t value;
    } mod_result_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

    // Offset-domain modular step; span must be at least 2.
    function automatic mod_result_t mod_step(input arith_t off, input step_e step, input arith_t span);
        mod_result_t res;
        arith_t      sum;
        res = '0;
        sum = off;
        case (step)
            STEP_M1: sum = (off == '0) ? (span - ARITH_ONE) : (off - ARITH_ONE);
            STEP_0:  sum = off;
            STEP_P1: sum = off + ARITH_ONE;
            STEP_P2: sum = off + ARITH_TWO;
            default: sum = off;
        endcase
        if ((step == STEP_P1 || step == STEP_P2) && sum >= span) begin
            sum            = sum - span;
            res.wrapped_up = 1'b1;
        end
        res.value = sum;
        return res;
    endfunction

endpackage

// File: rtl/digit_counter_param_if.sv
// rtl/digit_counter_param_if.sv - chaining and editing signals of one display digit
interface digit_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             clkin;
    logic             stopSignal;
    logic             plus;
    logic             minus;
    logic [WIDTH-1:0] dyn_max;
    logic [WIDTH-1:0] digit;
    logic             carry;
    logic             clkout;

    modport master (
        output clkin, stopSignal, plus, minus, dyn_max,
        input  digit, carry, clkout
    );

    modport slave (
        input  clkin, stopSignal, plus, minus, dyn_max,
        output digit, carry, clkout
    );
endinterface

// File: rtl/digit_counter_param_button_edge_repeat.sv
// rtl/digit_counter_param_button_edge_repeat.sv - button synchroniser, press edge and auto-repeat
module button_edge_repeat
    import digit_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2000000,
    parameter int REPEAT_CYCLES = 500000
) (
    input  logic MCLK,
    input  logic resetSignal,
    input  logic i_btn_n,
    output logic o_step
);

    localparam int CNT_W = clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    btn_state_e       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_step;
    logic             w_press;
    logic             w_released;

    assign w_press    = r_prev & ~r_sync2;
    assign w_released = r_sync2;
    assign o_step     = w_step;

    always_ff @(negedge MCLK or negedge resetSignal) begin
        if (!resetSignal) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= BTN_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The press edge is the first step; held time is then measured from it.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_step       = 1'b0;
        case (r_state)
            BTN_IDLE: begin
                if (w_press) begin
                    w_step       = 1'b1;
                    w_state_next = BTN_HOLD;
                    w_cnt_next   = '0;
                end
            end
            BTN_HOLD: begin
                if (w_released) begin
                    w_state_next = BTN_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_step       = 1'b1;
                    w_state_next = BTN_REPEAT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            BTN_REPEAT: begin
                if (w_released) begin
                    w_state_next = BTN_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_step     = 1'b1;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = BTN_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/digit_counter_param.sv
// rtl/digit_counter_param.sv - one display digit: tick counting, manual edit, carry and clkout
module digit_counter_param
    import digit_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MIN_DIGIT     = 0,
    parameter int MAX_DIGIT     = 9,
    parameter int HOLD_CYCLES   = 2000000,
    parameter int REPEAT_CYCLES = 500000
) (
    input  logic                 MCLK,
    input  logic                 resetSignal,
    digit_counter_param_if.slave bus
);

    localparam arith_t           MIN_A = arith_t'(MIN_DIGIT);
    localparam arith_t           MAX_A = arith_t'(MAX_DIGIT);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DIGIT);

    logic             r_tick_sync1;
    logic             r_tick_sync2;
    logic             r_tick_prev;
    logic [WIDTH-1:0] r_digit;
    logic             r_carry;
    logic             r_clkout;

    logic             w_tick;
    logic             w_plus_step;
    logic             w_minus_step;
    step_e            w_step;
    arith_t           w_dyn;
    arith_t           w_effmax;
    arith_t           w_span;
    arith_t           w_digit_a;
    arith_t           w_off;
    mod_result_t      w_res;
    logic [WIDTH-1:0] w_next_digit;
    logic             w_carry_next;
    logic             w_clkout_next;

    button_edge_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_plus (
        .MCLK       (MCLK),
        .resetSignal(resetSignal),
        .i_btn_n    (bus.plus),
        .o_step     (w_plus_step)
    );

    button_edge_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_minus (
        .MCLK       (MCLK),
        .resetSignal(resetSignal),
        .i_btn_n    (bus.minus),
        .o_step     (w_minus_step)
    );

    always_ff @(negedge MCLK or negedge resetSignal) begin
        if (!resetSignal) begin
            r_tick_sync1 <= 1'b1;
            r_tick_sync2 <= 1'b1;
            r_tick_prev  <= 1'b1;
        end else begin
            r_tick_sync1 <= bus.clkin;
            r_tick_sync2 <= r_tick_sync1;
            r_tick_prev  <= r_tick_sync2;
        end
    end

    assign w_tick = r_tick_prev & ~r_tick_sync2 & bus.stopSignal;

    always_comb begin
        w_step = STEP_0;
        case ({w_tick, w_plus_step, w_minus_step})
            3'b001:  w_step = STEP_M1;
            3'b010:  w_step = STEP_P1;
            3'b100:  w_step = STEP_P1;
            3'b110:  w_step = STEP_P2;
            3'b111:  w_step = STEP_P1;
            default: w_step = STEP_0;
        endcase
    end

    // A dyn_max below MIN_DIGIT is treated as the degenerate single-value span.
    always_comb begin
        w_dyn    = arith_t'(bus.dyn_max);
        w_effmax = (w_dyn < MAX_A) ? w_dyn : MAX_A;
        if (w_effmax < MIN_A) w_effmax = MIN_A;
        w_span    = w_effmax - MIN_A + ARITH_ONE;
        w_digit_a = arith_t'(r_digit);
        w_off     = w_digit_a - MIN_A;
    end

    always_comb begin
        w_next_digit = r_digit;
        w_carry_next = 1'b0;
        w_res        = '0;
        if (w_digit_a > w_effmax) begin
            w_next_digit = MIN_W;
        end else if (w_span == ARITH_ONE) begin
            w_next_digit = MIN_W;
            w_carry_next = w_tick;
        end else begin
            w_res        = mod_step(w_off, w_step, w_span);
            w_next_digit = WIDTH'(w_res.value + MIN_A);
            w_carry_next = w_tick & w_res.wrapped_up;
        end
        w_clkout_next = (arith_t'(w_next_digit) > (w_effmax >> 1));
    end

    always_ff @(negedge MCLK or negedge resetSignal) begin
        if (!resetSignal) begin
            r_digit  <= MIN_W;
            r_carry  <= 1'b0;
            r_clkout <= 1'b0;
        end else begin
            r_digit  <= w_next_digit;
            r_carry  <= w_carry_next;
            r_clkout <= w_clkout_next;
        end
    end

    assign bus.digit  = r_digit;
    assign bus.carry  = r_carry;
    assign bus.clkout = r_clkout;

endmodule

// File: tb/tb_digit_counter_param.sv
// tb/tb_digit_counter_param.sv - self-checking bench for digit_counter_param
module tb_digit_counter_param;

    localparam int MIN_D = 0;
    localparam int MAX_D = 9;
    localparam int HOLD  = 8;
    localparam int REP   = 4;

    logic MCLK;
    logic resetSignal;
    int   n_checks;
    int   n_pass;
    int   exp_digit;
    int   dyn_r;
    bit   stop_r;

    digit_counter_param_if #(.WIDTH(4)) bus ();

    digit_counter_param #(
        .WIDTH        (4),
        .MIN_DIGIT    (MIN_D),
        .MAX_DIGIT    (MAX_D),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .MCLK       (MCLK),
        .resetSignal(resetSignal),
        .bus        (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    function automatic int effmax(input int dyn);
        int em;
        em = (dyn < MAX_D) ? dyn : MAX_D;
        if (em < MIN_D) em = MIN_D;
        return em;
    endfunction

    function automatic void model(input int d, input bit t, input bit p, input bit m, input int dyn,
                                  output int nd, output bit c);
        int em, span, s;
        em   = effmax(dyn);
        span = em - MIN_D + 1;
        c    = 1'b0;
        if (d > em) begin
            nd = MIN_D;
        end else if (span == 1) begin
            nd = MIN_D;
            c  = t;
        end else begin
            s  = d - MIN_D + int'(t) + int'(p) - int'(m);
            c  = t && (s >= span);
            nd = MIN_D + (((s % span) + span) % span);
        end
    endfunction

    task automatic do_reset();
        @(posedge MCLK);
        resetSignal = 1'b0;
        repeat (2) @(posedge MCLK);
        resetSignal = 1'b1;
        exp_digit   = MIN_D;
        @(posedge MCLK);
    endtask

    task automatic set_dyn(input int v);
        @(posedge MCLK);
        bus.dyn_max = v[3:0];
        dyn_r       = v;
        repeat (2) @(posedge MCLK);
        if (exp_digit > effmax(dyn_r)) exp_digit = MIN_D;
    endtask

    task automatic step_cycle(input bit t, input bit p, input bit m, input string name);
        int nd;
        bit c;
        bit clk_exp;
        model(exp_digit, t && stop_r, p, m, dyn_r, nd, c);
        clk_exp = (nd > effmax(dyn_r) / 2);
        @(posedge MCLK);
        bus.stopSignal = stop_r;
        bus.clkin      = ~t;
        bus.plus       = ~p;
        bus.minus      = ~m;
        repeat (2) @(posedge MCLK);
        n_checks++;
        if (bus.digit !== 4'(exp_digit))
            $display("FAIL %s latency: digit=%0d required=%0d", name, bus.digit, exp_digit);
        else n_pass++;
        bus.clkin = 1'b1;
        bus.plus  = 1'b1;
        bus.minus = 1'b1;
        @(posedge MCLK);
        n_checks++;
        if (bus.digit !== 4'(nd) || bus.carry !== c || bus.clkout !== clk_exp)
            $display("FAIL %s: digit=%0d carry=%0b clkout=%0b required %0d/%0b/%0b",
                     name, bus.digit, bus.carry, bus.clkout, nd, c, clk_exp);
        else n_pass++;
        @(posedge MCLK);
        n_checks++;
        if (bus.carry !== 1'b0)
            $display("FAIL %s carry_width: carry=%0b required=0", name, bus.carry);
        else n_pass++;
        exp_digit = nd;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.digit !== 4'(MIN_D) || bus.carry !== 1'b0 || bus.clkout !== 1'b0)
            $display("FAIL reset_initial: digit=%0d carry=%0b clkout=%0b required 0/0/0",
                     bus.digit, bus.carry, bus.clkout);
        else n_pass++;
        resetSignal = 1'b1;
        exp_digit   = MIN_D;
        for (int i = 0; i < 7; i++) step_cycle(1, 0, 0, "reset_count");
        @(posedge MCLK);
        #2 resetSignal = 1'b0;
        #1;
        n_checks++;
        if (bus.digit !== 4'(MIN_D) || bus.carry !== 1'b0 || bus.clkout !== 1'b0)
            $display("FAIL reset_async: digit=%0d carry=%0b clkout=%0b required 0/0/0",
                     bus.digit, bus.carry, bus.clkout);
        else n_pass++;
        repeat (2) @(posedge MCLK);
        resetSignal = 1'b1;
        exp_digit   = MIN_D;
        step_cycle(1, 0, 0, "reset_resume");
    endtask

    task automatic test_ticks();
        do_reset();
        for (int i = 0; i < 10; i++) step_cycle(1, 0, 0, "tick_run");
        stop_r = 1'b0;
        for (int i = 0; i < 10; i++) step_cycle(1, 0, 0, "tick_stopped");
        stop_r = 1'b1;
    endtask

    task automatic test_buttons();
        do_reset();
        step_cycle(0, 0, 1, "minus_wrap");
        for (int i = 0; i < 5; i++) step_cycle(0, 1, 0, "plus_step");
        step_cycle(0, 1, 1, "plus_minus_cancel");
        step_cycle(1, 0, 1, "tick_minus_cancel");
    endtask

    task automatic test_tick_plus();
        do_reset();
        for (int i = 0; i < 8; i++) step_cycle(1, 0, 0, "to_eight");
        step_cycle(1, 1, 0, "tick_plus_at_8");
        for (int i = 0; i < 9; i++) step_cycle(1, 0, 0, "to_nine");
        step_cycle(1, 1, 0, "tick_plus_at_9");
        step_cycle(0, 1, 0, "plus_at_1");
    endtask

    task automatic test_hold_one(input int len, input string name);
        int steps;
        steps = 1;
        if (len - 1 >= HOLD) steps = 2 + (len - 1 - HOLD) / REP;
        @(posedge MCLK);
        bus.plus = 1'b0;
        repeat (len) @(posedge MCLK);
        bus.plus = 1'b1;
        repeat (8) @(posedge MCLK);
        exp_digit = (exp_digit + steps) % (MAX_D + 1);
        n_checks++;
        if (bus.digit !== 4'(exp_digit))
            $display("FAIL %s: held=%0d digit=%0d required=%0d", name, len, bus.digit, exp_digit);
        else n_pass++;
        repeat (20) @(posedge MCLK);
        n_checks++;
        if (bus.digit !== 4'(exp_digit))
            $display("FAIL %s_released: digit=%0d required=%0d", name, bus.digit, exp_digit);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        test_hold_one(22, "hold_to_five");
        for (int i = 0; i < 4; i++) test_hold_one(int'($urandom_range(2, 40)), "hold_random");
        do_reset();
        @(posedge MCLK);
        bus.plus = 1'b0;
        repeat (16) @(posedge MCLK);
        #2 resetSignal = 1'b0;
        #1;
        n_checks++;
        if (bus.digit !== 4'(MIN_D))
            $display("FAIL reset_in_repeat: digit=%0d required=%0d", bus.digit, MIN_D);
        else n_pass++;
        @(posedge MCLK);
        bus.plus = 1'b1;
        repeat (3) @(posedge MCLK);
        resetSignal = 1'b1;
        repeat (12) @(posedge MCLK);
        n_checks++;
        if (bus.digit !== 4'(MIN_D))
            $display("FAIL reset_repeat_after: digit=%0d required=%0d", bus.digit, MIN_D);
        else n_pass++;
        exp_digit = MIN_D;
    endtask

    task automatic test_limit();
        do_reset();
        for (int i = 0; i < 7; i++) step_cycle(1, 0, 0, "limit_prep");
        @(posedge MCLK);
        bus.dyn_max = 4'd3;
        dyn_r       = 3;
        @(posedge MCLK);
        n_checks++;
        if (bus.digit !== 4'(MIN_D) || bus.carry !== 1'b0)
            $display("FAIL limit_clip: digit=%0d carry=%0b required %0d/0", bus.digit, bus.carry, MIN_D);
        else n_pass++;
        exp_digit = MIN_D;
        for (int i = 0; i < 8; i++) step_cycle(1, 0, 0, "limit_count");
        set_dyn(0);
        step_cycle(1, 0, 0, "degenerate_tick");
        step_cycle(0, 1, 0, "degenerate_plus");
        step_cycle(0, 0, 1, "degenerate_minus");
        set_dyn(15);
    endtask

    task automatic test_random();
        int dyn_tab[4];
        dyn_tab = '{15, 9, 5, 3};
        for (int r = 0; r < 4; r++) begin
            set_dyn(dyn_tab[$urandom_range(0, 3)]);
            for (int i = 0; i < 12; i++) begin
                stop_r = ($urandom_range(0, 3) != 0);
                step_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 1) == 1, "random");
            end
        end
        stop_r = 1'b1;
        set_dyn(15);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        stop_r         = 1'b1;
        dyn_r          = 15;
        exp_digit      = MIN_D;
        resetSignal    = 1'b0;
        bus.clkin      = 1'b1;
        bus.plus       = 1'b1;
        bus.minus      = 1'b1;
        bus.stopSignal = 1'b1;
        bus.dyn_max    = 4'd15;
        repeat (3) @(posedge MCLK);
        test_reset();
        test_ticks();
        test_buttons();
        test_tick_plus();
        test_hold();
        test_limit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
